loadmem_arb: RTL

- Shares the single port of the CPU's program/data RAM between the CPU and the JTAG loader's write stream (we/addr/data strobes).
- Loader writes are buffered in a small FIFO and drained into free or stolen memory cycles.
- A starvation limit guarantees loader progress while the CPU is running; a hold input gives the loader every cycle while the CPU is held in reset.

---
 rtl/loadmem_arb_if.sv | 28 ++
 rtl/loadmem_arb.sv | 58 +++++
 2 files changed

// File: rtl/loadmem_arb_if.sv
// loadmem_arb_if: loader stream, CPU port and RAM port bundle for loadmem_arb
interface loadmem_arb_if #(parameter int AW = 13, parameter int DW = 16, parameter int DEPTH = 4);
  logic ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic cpu_hold;
  logic cpu_re;
  logic cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0] err;
  logic err_clr;
  logic [$clog2(DEPTH):0] fifo_cnt;
  modport slave (
    input ld_we, ld_addr, ld_data, cpu_hold, cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, err_clr,
    output cpu_stall, cpu_rdata, mem_addr, mem_we, mem_wdata, err, fifo_cnt
  );
  modport master (
    output ld_we, ld_addr, ld_data, cpu_hold, cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, err_clr,
    input cpu_stall, cpu_rdata, mem_addr, mem_we, mem_wdata, err, fifo_cnt
  );
endinterface

// File: rtl/loadmem_arb.sv
// loadmem_arb: shares the RAM port between the CPU and a FIFO-buffered loader write stream
module loadmem_arb #(
  parameter int AW = 13,
  parameter int DW = 16,
  parameter int DEPTH = 4,
  parameter int MAXWAIT = 7
) (
  input logic clk,
  input logic reset_n,
  loadmem_arb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [AW+DW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  logic [7:0] starve;
  logic [1:0] err;
  logic cpu_req, empty, full, addr_ok, ld_grant, push, ovf, bad;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic unused;
  assign unused = ^{bus.ld_addr[0], bus.ld_data[31:DW]};
  always_comb begin
    cpu_req = bus.cpu_re | bus.cpu_we;
    empty = cnt == '0;
    full = cnt == (PW+1)'(DEPTH);
    addr_ok = bus.ld_addr[31:AW+1] == '0;
    ld_grant = !empty && (bus.cpu_hold || !cpu_req || starve == 8'(MAXWAIT));
    push = bus.ld_we && addr_ok && (!full || ld_grant);
    ovf = bus.ld_we && addr_ok && full && !ld_grant;
    bad = bus.ld_we && !addr_ok;
    {head_addr, head_data} = fifo[rd_ptr];
  end
  assign bus.cpu_stall = cpu_req & ld_grant;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.mem_addr = ld_grant ? head_addr : bus.cpu_addr;
  assign bus.mem_wdata = ld_grant ? head_data : bus.cpu_wdata;
  assign bus.mem_we = ld_grant ? 1'b1 : bus.cpu_we;
  assign bus.err = err;
  assign bus.fifo_cnt = cnt;
  // Storage needs no reset: occupancy and pointers define what is valid
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {bus.ld_addr[AW:1], bus.ld_data[DW-1:0]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      starve <= '0;
      err <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(ld_grant);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(ld_grant);
      starve <= (empty || ld_grant) ? '0 : starve + 8'(starve != 8'(MAXWAIT));
      err <= (err & {2{!bus.err_clr}}) | {bad, ovf};
    end
endmodule
